// File: rtl/cpu_alu_pkg.sv
// Shared ALU definitions: sequencer states, packed-flag bit positions and default shift bound.
// The flag indices are common to every ALU flag producer, not only the left shifter.
package cpu_alu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam int unsigned FlagNIdx = 35;
    localparam int unsigned FlagZIdx = 34;
    localparam int unsigned FlagCIdx = 33;
    localparam int unsigned FlagVIdx = 32;

    localparam int unsigned ShiftBoundDefault = 5;

endpackage

// File: rtl/shift_left_seq_if.sv
// Operand/control bundle of the sequential left shifter.
// The tri-state result bus stays a plain port on the shifter.
interface shift_left_seq_if;

    logic [31:0] din;
    logic [4:0]  s_value;
    logic        start;
    logic        left_shift_en;
    logic        busy;
    logic        done;

    modport master (
        output din,
        output s_value,
        output start,
        output left_shift_en,
        input  busy,
        input  done
    );

    modport slave (
        input  din,
        input  s_value,
        input  start,
        input  left_shift_en,
        output busy,
        output done
    );

endinterface

// File: rtl/shift_left_seq.sv
// Multi-cycle left shifter: one bit per clock, carry/overflow accumulated along the way,
// packed result and flags driven onto a shared tri-state bus.
module shift_left_seq
    import cpu_alu_pkg::*;
#(
    parameter int unsigned N = ShiftBoundDefault
) (
    input  logic             clk,
    input  logic             rst,
    shift_left_seq_if.slave  bus,
    output wire  [35:0]      out
);

    localparam int unsigned CntW = 5;

    state_e            r_state, w_state_nxt;
    logic [31:0]       r_result, w_result_nxt;
    logic [CntW-1:0]   r_cnt, w_cnt_nxt;
    logic              r_c, w_c_nxt;
    logic              r_v, w_v_nxt;
    logic              r_sign, w_sign_nxt;
    logic              r_busy;
    logic              r_done;

    logic [CntW-1:0]   w_eff;
    logic              w_n;
    logic              w_z;
    logic [35:0]       w_packed;

    assign w_eff = ({27'd0, bus.s_value} > N) ? CntW'(N) : bus.s_value;

    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_cnt_nxt    = r_cnt;
        w_c_nxt      = r_c;
        w_v_nxt      = r_v;
        w_sign_nxt   = r_sign;
        unique case (r_state)
            StIdle: begin
                if (bus.start) begin
                    w_result_nxt = bus.din;
                    w_cnt_nxt    = w_eff;
                    w_c_nxt      = 1'b0;
                    w_v_nxt      = 1'b0;
                    w_sign_nxt   = bus.din[31];
                    w_state_nxt  = StShift;
                end
            end
            StShift: begin
                if (r_cnt != '0) begin
                    w_result_nxt = {r_result[30:0], 1'b0};
                    w_c_nxt      = r_result[31];
                    // Overflow once the bit moving into the sign slot differs from the original sign.
                    w_v_nxt      = r_v | (r_result[30] != r_sign);
                    w_cnt_nxt    = r_cnt - CntW'(1);
                end else begin
                    w_state_nxt  = StDone;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // busy/done are registered from the next state so they carry no combinational path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_result <= '0;
            r_cnt    <= '0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_sign   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_result <= w_result_nxt;
            r_cnt    <= w_cnt_nxt;
            r_c      <= w_c_nxt;
            r_v      <= w_v_nxt;
            r_sign   <= w_sign_nxt;
            r_busy   <= (w_state_nxt != StIdle);
            r_done   <= (w_state_nxt == StDone);
        end
    end

    assign w_n = r_result[31];
    assign w_z = (r_result == 32'd0);

    always_comb begin
        w_packed           = {4'b0000, r_result};
        w_packed[FlagNIdx] = w_n;
        w_packed[FlagZIdx] = w_z;
        w_packed[FlagCIdx] = r_c;
        w_packed[FlagVIdx] = r_v;
    end

    assign out      = bus.left_shift_en ? w_packed : {36{1'bz}};
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_shift_left_seq.sv
// Self-checking bench for shift_left_seq: directed cases, randomized operations against
// an arithmetic reference model, busy-start rejection, reset abort and bus tri-stating.
module tb_shift_left_seq;

    localparam int unsigned NBound = 5;
    localparam int MaxWait = 64;

    logic clk;
    logic rst;
    wire  [35:0] w_out;
    int checks;
    int failures;

    shift_left_seq_if u_if ();

    shift_left_seq #(
        .N (NBound)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if),
        .out (w_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the whole shift as one wide arithmetic operation.
    function automatic logic [35:0] model(input logic [31:0] d, input logic [4:0] s);
        int          eff;
        logic [63:0] wide;
        logic [31:0] res;
        logic        c;
        logic        v;
        eff  = (int'(s) > int'(NBound)) ? int'(NBound) : int'(s);
        wide = {32'd0, d} << eff;
        res  = wide[31:0];
        c    = wide[32];
        // Signed overflow: shifting back arithmetically fails to recover the operand.
        v    = (($signed(res) >>> eff) != $signed(d));
        return {res[31], (res == 32'd0), c, v, res};
    endfunction

    function automatic int eff_of(input logic [4:0] s);
        return (int'(s) > int'(NBound)) ? int'(NBound) : int'(s);
    endfunction

    // Drives one operation and reports what was observed; callers do the comparisons.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s,
                          output logic [35:0] o, output int lat, output int busy_cyc,
                          output bit timeout, output logic post_done, output logic post_busy,
                          output logic [35:0] o_idle);
        u_if.din     = d;
        u_if.s_value = s;
        u_if.start   = 1'b1;
        tick();
        u_if.start   = 1'b0;
        lat      = 1;
        busy_cyc = u_if.busy ? 1 : 0;
        while (!u_if.done && lat < MaxWait) begin
            tick();
            lat++;
            if (u_if.busy) busy_cyc++;
        end
        timeout = !u_if.done;
        o       = w_out;
        tick();
        post_done = u_if.done;
        post_busy = u_if.busy;
        o_idle    = w_out;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (u_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b want 0", u_if.busy);
        end
        checks++;
        if (u_if.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b want 0", u_if.done);
        end
        checks++;
        if (w_out !== 36'h4_0000_0000) begin
            failures++;
            $display("FAIL reset_out: got %h want 400000000", w_out);
        end
        // A start presented together with reset must be dropped.
        rst          = 1'b1;
        u_if.start   = 1'b1;
        u_if.din     = 32'h0000_0005;
        u_if.s_value = 5'd2;
        tick();
        rst        = 1'b0;
        u_if.start = 1'b0;
        tick();
        checks++;
        if (u_if.busy !== 1'b0 || w_out !== 36'h4_0000_0000) begin
            failures++;
            $display("FAIL reset_start_dropped: busy=%b out=%h want busy=0 out=400000000",
                     u_if.busy, w_out);
        end
    endtask

    task automatic test_directed();
        logic [31:0] d_tab [4];
        logic [4:0]  s_tab [4];
        logic [35:0] e_tab [4];
        int          l_tab [4];
        logic [35:0] o, o_idle;
        int          lat, busy_cyc;
        bit          timeout;
        logic        pd, pb;
        d_tab = '{32'h0000_0001, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        s_tab = '{5'd3, 5'd1, 5'd9, 5'd0};
        e_tab = '{36'h0_0000_0008, 36'h3_0000_0002, 36'hA_FFFF_FFE0, 36'h4_0000_0000};
        l_tab = '{5, 3, 7, 2};
        for (int i = 0; i < 4; i++) begin
            run_op(d_tab[i], s_tab[i], o, lat, busy_cyc, timeout, pd, pb, o_idle);
            checks++;
            if (timeout || lat != l_tab[i]) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d edges (timeout=%0b) want %0d",
                         i, lat, timeout, l_tab[i]);
            end
            checks++;
            if (o !== e_tab[i]) begin
                failures++;
                $display("FAIL dir%0d_out: got %h want %h", i, o, e_tab[i]);
            end
            // Busy covers every SHIFT cycle plus the DONE cycle.
            checks++;
            if (busy_cyc != l_tab[i]) begin
                failures++;
                $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, busy_cyc, l_tab[i]);
            end
            checks++;
            if (pd !== 1'b0 || pb !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_after_done: done=%b busy=%b want 0 0", i, pd, pb);
            end
            checks++;
            if (o_idle !== e_tab[i]) begin
                failures++;
                $display("FAIL dir%0d_hold: got %h want %h", i, o_idle, e_tab[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [4:0]  s;
        logic [35:0] o, o_idle, exp;
        int          lat, busy_cyc;
        bit          timeout;
        logic        pd, pb;
        for (int i = 0; i < 30; i++) begin
            d = $urandom();
            if (i % 5 == 1) d = {{8{d[31]}}, d[23:0]};
            s = 5'($urandom_range(0, 31));
            exp = model(d, s);
            run_op(d, s, o, lat, busy_cyc, timeout, pd, pb, o_idle);
            checks++;
            if (timeout || lat != eff_of(s) + 2 || o !== exp || pd !== 1'b0) begin
                failures++;
                $display("FAIL rand%0d: din=%h s=%0d got out=%h lat=%0d pdone=%b want out=%h lat=%0d",
                         i, d, s, o, lat, pd, exp, eff_of(s) + 2);
            end
        end
    endtask

    task automatic test_busy_start();
        logic [35:0] exp;
        int          lat;
        bit          seen_busy;
        exp          = model(32'h1234_5678, 5'd4);
        u_if.din     = 32'h1234_5678;
        u_if.s_value = 5'd4;
        u_if.start   = 1'b1;
        tick();
        u_if.start   = 1'b0;
        tick();
        u_if.din     = 32'hFFFF_0000;
        u_if.s_value = 5'd0;
        u_if.start   = 1'b1;
        tick();
        u_if.start   = 1'b0;
        lat = 3;
        while (!u_if.done && lat < MaxWait) begin
            tick();
            lat++;
        end
        checks++;
        if (!u_if.done || lat != 6 || w_out !== exp) begin
            failures++;
            $display("FAIL busy_start_ignored: out=%h lat=%0d want out=%h lat=6", w_out, lat, exp);
        end
        seen_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (u_if.busy) seen_busy = 1'b1;
        end
        checks++;
        if (seen_busy) begin
            failures++;
            $display("FAIL busy_start_no_queue: got busy=1 after done want 0");
        end
    endtask

    task automatic test_reset_abort();
        bit seen_done;
        u_if.din     = 32'h00F0_0001;
        u_if.s_value = 5'd4;
        u_if.start   = 1'b1;
        tick();
        u_if.start   = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen_done = u_if.done;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (u_if.done) seen_done = 1'b1;
        end
        checks++;
        if (seen_done) begin
            failures++;
            $display("FAIL abort_no_done: got done pulse want none");
        end
        checks++;
        if (u_if.busy !== 1'b0 || w_out !== 36'h4_0000_0000) begin
            failures++;
            $display("FAIL abort_state: busy=%b out=%h want busy=0 out=400000000", u_if.busy, w_out);
        end
    endtask

    task automatic test_tristate();
        logic [35:0] o, o_idle;
        int          lat, busy_cyc;
        bit          timeout, leaked;
        logic        pd, pb;
        run_op(32'h8000_0001, 5'd1, o, lat, busy_cyc, timeout, pd, pb, o_idle);
        u_if.left_shift_en = 1'b0;
        #1;
        // Two-state simulators resolve an undriven bus to zero rather than z.
        checks++;
        if (w_out !== {36{1'bz}} && w_out !== 36'd0) begin
            failures++;
            $display("FAIL tristate_idle: got %h want all z", w_out);
        end
        leaked = 1'b0;
        u_if.din     = 32'h0000_0001;
        u_if.s_value = 5'd3;
        u_if.start   = 1'b1;
        tick();
        u_if.start   = 1'b0;
        lat = 1;
        while (!u_if.done && lat < MaxWait) begin
            if (w_out !== {36{1'bz}} && w_out !== 36'd0) leaked = 1'b1;
            tick();
            lat++;
        end
        if (w_out !== {36{1'bz}} && w_out !== 36'd0) leaked = 1'b1;
        checks++;
        if (leaked || !u_if.done) begin
            failures++;
            $display("FAIL tristate_busy: leaked=%0b done=%b want no drive and done", leaked, u_if.done);
        end
        tick();
        u_if.left_shift_en = 1'b1;
        #1;
        checks++;
        if (w_out !== 36'h0_0000_0008) begin
            failures++;
            $display("FAIL tristate_reenable: got %h want 000000008", w_out);
        end
    endtask

    initial begin
        checks             = 0;
        failures           = 0;
        rst                = 1'b1;
        u_if.din           = '0;
        u_if.s_value       = '0;
        u_if.start         = 1'b0;
        u_if.left_shift_en = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_busy_start();
        test_reset_abort();
        test_tristate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
